// File: rtl/video_vicii_palette.sv
// VIC-II pixel colour stage: 4-bit colour index to 24-bit RGB through a
// run-time writable 16-entry palette, with syncs/blanks delayed to match.
module video_vicii_palette (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic [3:0]  idx,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        hblank_i,
  input  logic        vblank_i,
  input  logic        wr,
  input  logic [3:0]  wr_addr,
  input  logic [23:0] wr_data,
  output logic        wr_busy,
  output logic [7:0]  Ro,
  output logic [7:0]  Go,
  output logic [7:0]  Bo,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        hblank_o,
  output logic        vblank_o
);

  typedef enum logic [1:0] {
    RESET,
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } sync_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        ld;
  logic        we;
  logic [3:0]  waddr;
  logic [23:0] wdata;
  logic [23:0] pal [16];

  logic [3:0]  s1_idx;
  sync_t       s1_sy;
  sync_t       s2_sy;
  logic [23:0] s2_rgb;

  function automatic logic [23:0] dflt(input logic [3:0] a);
    case (a)
      4'd1:    dflt = 24'hFFFFFF;
      4'd2:    dflt = 24'h68372B;
      4'd3:    dflt = 24'h70A4B2;
      4'd4:    dflt = 24'h6F3D86;
      4'd5:    dflt = 24'h588D43;
      4'd6:    dflt = 24'h352879;
      4'd7:    dflt = 24'hB8C76F;
      4'd8:    dflt = 24'h6F4F25;
      4'd9:    dflt = 24'h433900;
      4'd10:   dflt = 24'h9A6759;
      4'd11:   dflt = 24'h444444;
      4'd12:   dflt = 24'h6C6C6C;
      4'd13:   dflt = 24'h9AD284;
      4'd14:   dflt = 24'h6C5EB5;
      4'd15:   dflt = 24'h959595;
      default: dflt = 24'h000000;
    endcase
  endfunction

  // the first clk out of RESET already loads entry 0
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld        = 1'b0;
    wr_busy   = 1'b1;
    unique case (state)
      RESET: begin
        state_nxt = INIT;
        ld        = 1'b1;
        cnt_nxt   = cnt + 5'd1;
      end
      INIT: begin
        if (cnt[4]) begin
          state_nxt = RUN;
        end else begin
          ld      = 1'b1;
          cnt_nxt = cnt + 5'd1;
        end
      end
      RUN: begin
        wr_busy = 1'b0;
      end
      default: begin
        state_nxt = RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RESET;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign we    = reset_n & (ld | (wr & (state == RUN)));
  assign waddr = ld ? cnt[3:0] : wr_addr;
  assign wdata = ld ? dflt(cnt[3:0]) : wr_data;

  always_ff @(posedge clk) begin
    if (we) begin
      pal[waddr] <= wdata;
    end
  end

  // S2 samples pal before any same-edge write lands: read-first
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_idx <= 4'd0;
      s1_sy  <= '0;
      s2_sy  <= '0;
      s2_rgb <= 24'd0;
    end else if (ce_pix) begin
      s1_idx <= idx;
      s1_sy  <= '{hsync_i, vsync_i, hblank_i, vblank_i};
      s2_sy  <= s1_sy;
      if (wr_busy || s1_sy.hb || s1_sy.vb) begin
        s2_rgb <= 24'd0;
      end else begin
        s2_rgb <= pal[s1_idx];
      end
    end
  end

  assign Ro       = s2_rgb[23:16];
  assign Go       = s2_rgb[15:8];
  assign Bo       = s2_rgb[7:0];
  assign hsync_o  = s2_sy.hs;
  assign vsync_o  = s2_sy.vs;
  assign hblank_o = s2_sy.hb;
  assign vblank_o = s2_sy.vb;

endmodule

// File: tb/tb_video_vicii_palette.sv
// Bench for video_vicii_palette: vector table through a scoreboard queue,
// plus hand sequences for init, write collision and reset mid-init.
module tb_video_vicii_palette;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_pix;
  logic [3:0]  idx;
  logic        hsync_i, vsync_i, hblank_i, vblank_i;
  logic        wr;
  logic [3:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_busy;
  logic [7:0]  Ro, Go, Bo;
  logic        hsync_o, vsync_o, hblank_o, vblank_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [23:0] rgb;
    logic [3:0]  sy;
  } exp_t;

  typedef struct {
    logic [3:0]  idx;
    logic [3:0]  sy;
    logic [23:0] rgb;
  } vec_t;

  exp_t        sbq[$];
  exp_t        held;
  vec_t        vt[20];
  logic [23:0] defp[16];

  always #5 clk = ~clk;

  video_vicii_palette dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce_pix   (ce_pix),
    .idx      (idx),
    .hsync_i  (hsync_i),
    .vsync_i  (vsync_i),
    .hblank_i (hblank_i),
    .vblank_i (vblank_i),
    .wr       (wr),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_busy  (wr_busy),
    .Ro       (Ro),
    .Go       (Go),
    .Bo       (Bo),
    .hsync_o  (hsync_o),
    .vsync_o  (vsync_o),
    .hblank_o (hblank_o),
    .vblank_o (vblank_o)
  );

  function automatic logic [23:0] rgb();
    return {Ro, Go, Bo};
  endfunction

  function automatic logic [3:0] syo();
    return {hsync_o, vsync_o, hblank_o, vblank_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic pix(input logic [3:0] i, input logic [3:0] sy,
                     input logic [23:0] want);
    exp_t e;
    idx = i;
    {hsync_i, vsync_i, hblank_i, vblank_i} = sy;
    ce_pix = 1'b1;
    e.rgb = want;
    e.sy  = sy;
    sbq.push_back(e);
    step();
    ce_pix = 1'b0;
    wr     = 1'b0;
    if (sbq.size() >= 2) begin
      e    = sbq.pop_front();
      held = e;
      chk("pix_rgb", {8'd0, rgb()}, {8'd0, e.rgb});
      chk("pix_sync", {28'd0, syo()}, {28'd0, e.sy});
    end
  endtask

  task automatic idle_hold();
    ce_pix = 1'b0;
    idx    = 4'd15;
    {hsync_i, vsync_i, hblank_i, vblank_i} = 4'b1111;
    step();
    chk("hold_rgb", {8'd0, rgb()}, {8'd0, held.rgb});
    chk("hold_sync", {28'd0, syo()}, {28'd0, held.sy});
  endtask

  initial begin
    defp = '{24'h000000, 24'hFFFFFF, 24'h68372B, 24'h70A4B2,
             24'h6F3D86, 24'h588D43, 24'h352879, 24'hB8C76F,
             24'h6F4F25, 24'h433900, 24'h9A6759, 24'h444444,
             24'h6C6C6C, 24'h9AD284, 24'h6C5EB5, 24'h959595};
    for (int i = 0; i < 16; i++) begin
      vt[i].idx = 4'(i);
      vt[i].sy  = (i == 3) ? 4'b1000 : 4'b0000;
      vt[i].rgb = defp[i];
    end
    vt[16] = '{4'd1, 4'b0010, 24'h000000};
    vt[17] = '{4'd1, 4'b0001, 24'h000000};
    vt[18] = '{4'd1, 4'b0000, 24'hFFFFFF};
    vt[19] = '{4'd5, 4'b0000, 24'h588D43};

    reset_n  = 1'b0;
    ce_pix   = 1'b1;
    idx      = 4'd1;
    hsync_i  = 1'b1;
    vsync_i  = 1'b0;
    hblank_i = 1'b0;
    vblank_i = 1'b0;
    wr       = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 24'd0;
    held     = '0;

    repeat (3) step();
    chk("rst_rgb", {8'd0, rgb()}, 32'd0);
    chk("rst_sync", {28'd0, syo()}, 32'd0);
    chk("rst_busy", {31'd0, wr_busy}, 32'd1);

    reset_n = 1'b1;
    hsync_i = 1'b0;
    idx     = 4'd7;
    ce_pix  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        wr      = 1'b1;
        wr_addr = 4'd5;
        wr_data = 24'hFFFFFF;
      end
      hsync_i = (k == 5);
      step();
      wr = 1'b0;
      chk("init_busy", {31'd0, wr_busy}, 32'd1);
      chk("init_rgb", {8'd0, rgb()}, 32'd0);
      chk("init_hsync", {31'd0, hsync_o}, {31'd0, (k == 6)});
    end
    hsync_i = 1'b0;
    step();
    chk("run_busy", {31'd0, wr_busy}, 32'd0);
    chk("edge17_rgb", {8'd0, rgb()}, 32'd0);
    step();
    chk("first_rgb", {8'd0, rgb()}, 32'hB8C76F);
    ce_pix = 1'b0;
    sbq.delete();

    for (int i = 0; i < 20; i++) begin
      pix(vt[i].idx, vt[i].sy, vt[i].rgb);
      if (i > 0) idle_hold();
    end
    pix(4'd0, 4'b0000, 24'h000000);
    idle_hold();

    pix(4'd2, 4'b0000, 24'h68372B);
    wr      = 1'b1;
    wr_addr = 4'd2;
    wr_data = 24'h123456;
    pix(4'd0, 4'b0000, 24'h000000);
    pix(4'd2, 4'b0000, 24'h123456);
    pix(4'd0, 4'b0000, 24'h000000);

    wr      = 1'b1;
    wr_addr = 4'd12;
    wr_data = 24'hABCDEF;
    ce_pix  = 1'b0;
    step();
    wr = 1'b0;
    pix(4'd12, 4'b0000, 24'hABCDEF);
    pix(4'd13, 4'b0100, 24'h9AD284);
    chk("pre_rst_rgb", {8'd0, rgb()}, 32'hABCDEF);

    reset_n = 1'b0;
    ce_pix  = 1'b1;
    step();
    chk("rst2_rgb", {8'd0, rgb()}, 32'd0);
    chk("rst2_sync", {28'd0, syo()}, 32'd0);
    chk("rst2_busy", {31'd0, wr_busy}, 32'd1);
    reset_n = 1'b1;
    ce_pix  = 1'b0;
    repeat (8) step();
    chk("mid_busy", {31'd0, wr_busy}, 32'd1);
    reset_n = 1'b0;
    step();
    chk("rst3_rgb", {8'd0, rgb()}, 32'd0);
    chk("rst3_busy", {31'd0, wr_busy}, 32'd1);
    reset_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk("reinit_busy", {31'd0, wr_busy}, {31'd0, (k < 17)});
    end
    sbq.delete();
    pix(4'd2, 4'b0000, 24'h68372B);
    pix(4'd12, 4'b0000, 24'h6C6C6C);
    pix(4'd8, 4'b0000, 24'h6F4F25);
    pix(4'd1, 4'b0000, 24'hFFFFFF);
    pix(4'd0, 4'b0000, 24'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
